alu_op_sequencer: RTL and testbench

Sequences instruction-level arithmetic/logic requests from the decode/control unit onto the shared 6502 ALU. It latches operands and sets up ALU operand, function and carry inputs for each operation: operand inversion for SBC/CMP, constant injection for INC/DEC, doubling for ASL/ROL. It captures the ALU result, derives the N/Z/C/V flags, and optionally runs a BCD correction pass. Sits between the control unit and the ALU and is the only driver of the ALU input ports.

---
 rtl/alu_op_sequencer_if.sv | 26 ++
 rtl/alu_op_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response bus between the control unit and alu_op_sequencer.
// The control unit uses the master modport; the sequencer uses the slave modport.
interface alu_op_sequencer_if #(
   parameter int REG_WIDTH = 8
);
   logic                 req;
   logic [3:0]           cmd;
   logic [REG_WIDTH-1:0] op_a;
   logic [REG_WIDTH-1:0] op_b;
   logic [REG_WIDTH-1:0] status_in;
   logic                 busy;
   logic                 done;
   logic [REG_WIDTH-1:0] result;
   logic                 result_we;
   logic [REG_WIDTH-1:0] status_out;

   modport master (
      output req, cmd, op_a, op_b, status_in,
      input  busy, done, result, result_we, status_out
   );

   modport slave (
      input  req, cmd, op_a, op_b, status_in,
      output busy, done, result, result_we, status_out
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives the shared 6502 ALU for one control-unit request at a time and derives NZCV.
// Define ALU_SEQ_BCD_EN to add the decimal-mode DADJ/DCAPT correction pass for ADC/SBC.
module alu_op_sequencer #(
   parameter int REG_WIDTH = 8,
   parameter int OPP_WIDTH = 4
) (
   input  logic                 phi1,
   input  logic                 reset_n,
   alu_op_sequencer_if.slave    ctrl,
   output logic [REG_WIDTH-1:0] alu_a,
   output logic [REG_WIDTH-1:0] alu_b,
   output logic [OPP_WIDTH-1:0] alu_func,
   output logic                 alu_carry_in,
   input  logic [REG_WIDTH-1:0] alu_dout,
   input  logic [REG_WIDTH-1:0] alu_status
);
   localparam int MSB = REG_WIDTH - 1;

   localparam logic [OPP_WIDTH-1:0] ALU_SUM = OPP_WIDTH'(0);
   localparam logic [OPP_WIDTH-1:0] ALU_AND = OPP_WIDTH'(1);
   localparam logic [OPP_WIDTH-1:0] ALU_OR  = OPP_WIDTH'(2);
   localparam logic [OPP_WIDTH-1:0] ALU_XOR = OPP_WIDTH'(3);
   localparam logic [OPP_WIDTH-1:0] ALU_NOP = {OPP_WIDTH{1'b1}};

   localparam logic [3:0] CMD_ADC = 4'h0, CMD_SBC = 4'h1, CMD_AND = 4'h2, CMD_ORA = 4'h3;
   localparam logic [3:0] CMD_EOR = 4'h4, CMD_ASL = 4'h5, CMD_LSR = 4'h6, CMD_ROL = 4'h7;
   localparam logic [3:0] CMD_ROR = 4'h8, CMD_INC = 4'h9, CMD_DEC = 4'hA, CMD_CMP = 4'hB;
   localparam logic [3:0] CMD_BIT = 4'hC;

   localparam int P_C = 0, P_Z = 1, P_D = 3, P_V = 6, P_N = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
`ifdef ALU_SEQ_BCD_EN
      S_DADJ,
      S_DCAPT,
`endif
      S_DONE
   } state_t;

   state_t               state, state_nxt;
   logic                 accept;
   logic [3:0]           cmd_q;
   logic [REG_WIDTH-1:0] op_a_q, op_b_q, st_q;
   logic                 we_q;

   logic [REG_WIDTH-1:0] iss_a, iss_b;
   logic                 iss_cin;
   logic [OPP_WIDTH-1:0] iss_func;

   logic                 v_bin, shift_in;
   logic [REG_WIDTH-1:0] shift_res, cap_res, cap_st;
   logic                 cap_we;

   // Only the carry bit of the ALU status is meaningful here.
   logic unused_status;
   assign unused_status = ^alu_status[MSB:1];

`ifdef ALU_SEQ_BCD_EN
   logic                 bcd_go, hc;
   logic [4:0]           lo_sum;
   logic [REG_WIDTH:0]   bcd_fix;
   logic                 bcd_c_q, bcd_v_q;
   logic [REG_WIDTH-1:0] dcap_st;

   // Returns {carry_out, correction operand}; SBC corrections are pre-negated.
   function automatic logic [REG_WIDTH:0] bcd_adjust(input logic sub, input logic half_c,
                                                     input logic c_bin, input logic [REG_WIDTH-1:0] r);
      logic                 lo, hi;
      logic [REG_WIDTH-1:0] corr;
      if (sub) begin
         lo = !half_c;
         hi = !c_bin;
      end else begin
         lo = half_c || (r[3:0] > 4'd9);
         hi = c_bin || (r > REG_WIDTH'(8'h99));
      end
      corr = REG_WIDTH'({hi ? 4'h6 : 4'h0, lo ? 4'h6 : 4'h0});
      if (sub)
         return {c_bin, -corr};
      return {c_bin | hi, corr};
   endfunction

   // ALU inputs still hold the binary-pass operands during CAPTURE.
   always_comb begin
      lo_sum  = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, alu_carry_in};
      hc      = lo_sum[4];
      bcd_go  = ((cmd_q == CMD_ADC) || (cmd_q == CMD_SBC)) && st_q[P_D];
      bcd_fix = bcd_adjust(cmd_q == CMD_SBC, hc, alu_status[0], alu_dout);
      dcap_st        = st_q;
      dcap_st[P_N]   = alu_dout[MSB];
      dcap_st[P_Z]   = (alu_dout == '0);
      dcap_st[P_C]   = bcd_c_q;
      dcap_st[P_V]   = bcd_v_q;
   end
`endif

   always_ff @(posedge phi1) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      accept         = 1'b0;
      ctrl.busy      = (state != S_IDLE);
      ctrl.done      = 1'b0;
      ctrl.result_we = 1'b0;
      case (state)
         S_IDLE: begin
            if (ctrl.req) begin
               accept    = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE:   state_nxt = S_CAPTURE;
`ifdef ALU_SEQ_BCD_EN
         S_CAPTURE: state_nxt = bcd_go ? S_DADJ : S_DONE;
         S_DADJ:    state_nxt = S_DCAPT;
         S_DCAPT:   state_nxt = S_DONE;
`else
         S_CAPTURE: state_nxt = S_DONE;
`endif
         S_DONE: begin
            ctrl.done      = 1'b1;
            ctrl.result_we = we_q;
            state_nxt      = S_IDLE;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      iss_a    = ctrl.op_a;
      iss_b    = ctrl.op_b;
      iss_cin  = 1'b0;
      iss_func = ALU_NOP;
      case (ctrl.cmd)
         CMD_ADC: begin iss_func = ALU_SUM; iss_cin = ctrl.status_in[P_C]; end
         CMD_SBC: begin iss_func = ALU_SUM; iss_b = ~ctrl.op_b; iss_cin = ctrl.status_in[P_C]; end
         CMD_CMP: begin iss_func = ALU_SUM; iss_b = ~ctrl.op_b; iss_cin = 1'b1; end
         CMD_INC: begin iss_func = ALU_SUM; iss_b = REG_WIDTH'(1); end
         CMD_DEC: begin iss_func = ALU_SUM; iss_b = '1; end
         CMD_ASL: begin iss_func = ALU_SUM; iss_b = ctrl.op_a; end
         CMD_ROL: begin iss_func = ALU_SUM; iss_b = ctrl.op_a; iss_cin = ctrl.status_in[P_C]; end
         CMD_AND, CMD_BIT: iss_func = ALU_AND;
         CMD_ORA: iss_func = ALU_OR;
         CMD_EOR: iss_func = ALU_XOR;
         default: iss_func = ALU_NOP;
      endcase
   end

   // Binary-pass result and flag merge; bits not owned by the command pass through.
   always_comb begin
      v_bin     = (alu_a[MSB] == alu_b[MSB]) && (alu_dout[MSB] != alu_a[MSB]);
      shift_in  = (cmd_q == CMD_LSR) ? 1'b0 : st_q[P_C];
      shift_res = {shift_in, op_a_q[MSB:1]};
      cap_res   = alu_dout;
      cap_st    = st_q;
      cap_we    = 1'b1;
      case (cmd_q)
         CMD_ADC, CMD_SBC, CMD_CMP, CMD_ASL, CMD_ROL: begin
            cap_st[P_N] = alu_dout[MSB];
            cap_st[P_Z] = (alu_dout == '0);
            cap_st[P_C] = alu_status[0];
            if (cmd_q == CMD_ADC || cmd_q == CMD_SBC) cap_st[P_V] = v_bin;
            if (cmd_q == CMD_CMP) cap_we = 1'b0;
         end
         CMD_LSR, CMD_ROR: begin
            cap_res     = shift_res;
            cap_st[P_N] = shift_res[MSB];
            cap_st[P_Z] = (shift_res == '0);
            cap_st[P_C] = op_a_q[0];
         end
         CMD_INC, CMD_DEC, CMD_AND, CMD_ORA, CMD_EOR: begin
            cap_st[P_N] = alu_dout[MSB];
            cap_st[P_Z] = (alu_dout == '0);
         end
         CMD_BIT: begin
            cap_st[P_N] = op_b_q[MSB];
            cap_st[P_V] = op_b_q[MSB-1];
            cap_st[P_Z] = (alu_dout == '0);
            cap_we      = 1'b0;
         end
         default: begin
            cap_res = ctrl.result;
            cap_we  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge phi1) begin
      if (!reset_n) begin
         alu_a           <= '0;
         alu_b           <= '0;
         alu_carry_in    <= 1'b0;
         alu_func        <= ALU_NOP;
         ctrl.result     <= '0;
         ctrl.status_out <= '0;
         we_q            <= 1'b0;
      end else begin
         // Function falls back to NOP every cycle so each issue is a visible change.
         alu_func <= ALU_NOP;
         if (accept) begin
            cmd_q        <= ctrl.cmd;
            op_a_q       <= ctrl.op_a;
            op_b_q       <= ctrl.op_b;
            st_q         <= ctrl.status_in;
            alu_a        <= iss_a;
            alu_b        <= iss_b;
            alu_carry_in <= iss_cin;
            alu_func     <= iss_func;
         end
         if (state == S_CAPTURE) begin
`ifdef ALU_SEQ_BCD_EN
            if (bcd_go) begin
               alu_a        <= alu_dout;
               alu_b        <= bcd_fix[MSB:0];
               alu_carry_in <= 1'b0;
               alu_func     <= ALU_SUM;
               bcd_c_q      <= bcd_fix[REG_WIDTH];
               bcd_v_q      <= v_bin;
            end else
`endif
            begin
               ctrl.result     <= cap_res;
               ctrl.status_out <= cap_st;
               we_q            <= cap_we;
            end
         end
`ifdef ALU_SEQ_BCD_EN
         if (state == S_DCAPT) begin
            ctrl.result     <= alu_dout;
            ctrl.status_out <= dcap_st;
            we_q            <= 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered behavioural 6502 ALU.
// Expectations for the decimal-mode cases follow ALU_SEQ_BCD_EN when it is defined.
module tb_alu_op_sequencer;
   logic       phi1 = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] alu_a, alu_b;
   logic [3:0] alu_func;
   logic       alu_carry_in;
   logic [7:0] alu_dout = 8'h00;
   logic [7:0] alu_status = 8'h00;
   int         errors = 0;
   int         checks = 0;

   alu_op_sequencer_if #(.REG_WIDTH(8)) ctrl ();

   alu_op_sequencer #(.REG_WIDTH(8), .OPP_WIDTH(4)) dut (
      .phi1         (phi1),
      .reset_n      (reset_n),
      .ctrl         (ctrl),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_func     (alu_func),
      .alu_carry_in (alu_carry_in),
      .alu_dout     (alu_dout),
      .alu_status   (alu_status)
   );

   always #5 phi1 = ~phi1;

   // ALU: SUM=0 AND=1 OR=2 XOR=3, NOP=F holds; result registered on phi1.
   always @(posedge phi1) begin : alu_model
      logic [8:0] s;
      s = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
      case (alu_func)
         4'h0: begin alu_dout <= s[7:0]; alu_status <= {7'b0, s[8]}; end
         4'h1: alu_dout <= alu_a & alu_b;
         4'h2: alu_dout <= alu_a | alu_b;
         4'h3: alu_dout <= alu_a ^ alu_b;
         default: ;
      endcase
   end

   task automatic run_op(input logic [3:0] c, input logic [7:0] a, b, st, output int lat,
                         output logic [7:0] res, st_o, output logic we, output logic [3:0] f1,
                         output logic [7:0] b1, output logic cin1, output logic [3:0] f2,
                         output logic nonnop);
      ctrl.cmd = c; ctrl.op_a = a; ctrl.op_b = b; ctrl.status_in = st; ctrl.req = 1'b1;
      @(posedge phi1); #1;
      ctrl.req = 1'b0;
      lat = -1; res = 8'h00; st_o = 8'h00; we = 1'b0; nonnop = 1'b0;
      f1 = alu_func; b1 = alu_b; cin1 = alu_carry_in; f2 = 4'h0;
      for (int e = 0; e < 12; e++) begin
         if (e == 1) f2 = alu_func;
         if (alu_func !== 4'hF) nonnop = 1'b1;
         if (ctrl.done === 1'b1) begin
            lat = e + 1; res = ctrl.result; st_o = ctrl.status_out; we = ctrl.result_we;
            break;
         end
         @(posedge phi1); #1;
      end
      @(posedge phi1); #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(posedge phi1);
      #1;
      checks++;
      if ({ctrl.busy, ctrl.done, ctrl.result_we} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 000", {ctrl.busy, ctrl.done, ctrl.result_we});
      end
      checks++;
      if ({ctrl.result, ctrl.status_out} !== 16'h0000) begin
         errors++; $display("FAIL reset_result: got %h expected 0000", {ctrl.result, ctrl.status_out});
      end
      checks++;
      if ({alu_a, alu_b, alu_carry_in, alu_func} !== {8'h00, 8'h00, 1'b0, 4'hF}) begin
         errors++; $display("FAIL reset_alu: got %h %h %b %h expected 00 00 0 f", alu_a, alu_b, alu_carry_in, alu_func);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_adc;
      int lat; logic [7:0] r, s, b1; logic we, cin1, nn; logic [3:0] f1, f2;
      run_op(4'h0, 8'h50, 8'h50, 8'h00, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (r !== 8'hA0) begin errors++; $display("FAIL adc_result: got %h expected a0", r); end
      checks++; if (s !== 8'hC0) begin errors++; $display("FAIL adc_status: got %h expected c0", s); end
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL adc_we: got %b expected 1", we); end
      checks++; if (lat != 3) begin errors++; $display("FAIL adc_latency: got %0d expected 3", lat); end
      checks++;
      if ({f1, b1, cin1} !== {4'h0, 8'h50, 1'b0}) begin
         errors++; $display("FAIL adc_issue: got %h %h %b expected 0 50 0", f1, b1, cin1);
      end
      checks++; if (f2 !== 4'hF) begin errors++; $display("FAIL adc_capture_nop: got %h expected f", f2); end
      checks++;
      if ({ctrl.done, ctrl.busy} !== 2'b00) begin
         errors++; $display("FAIL adc_after_done: got %b expected 00", {ctrl.done, ctrl.busy});
      end
   endtask

   task automatic test_sbc_inc;
      int lat; logic [7:0] r, s, b1; logic we, cin1, nn; logic [3:0] f1, f2;
      run_op(4'h1, 8'h00, 8'h01, 8'h01, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (r !== 8'hFF) begin errors++; $display("FAIL sbc_result: got %h expected ff", r); end
      checks++; if (s !== 8'h80) begin errors++; $display("FAIL sbc_status: got %h expected 80", s); end
      checks++;
      if ({b1, cin1} !== {8'hFE, 1'b1}) begin
         errors++; $display("FAIL sbc_issue: got %h %b expected fe 1", b1, cin1);
      end
      run_op(4'h9, 8'hFF, 8'h00, 8'h01, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL inc_result: got %h expected 00", r); end
      checks++; if (s !== 8'h03) begin errors++; $display("FAIL inc_status: got %h expected 03", s); end
   endtask

   task automatic test_cmp_bit;
      int lat; logic [7:0] r, s, b1; logic we, cin1, nn; logic [3:0] f1, f2;
      run_op(4'hB, 8'h40, 8'h40, 8'h00, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (s !== 8'h03) begin errors++; $display("FAIL cmp_status: got %h expected 03", s); end
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL cmp_we: got %b expected 0", we); end
      checks++;
      if ({b1, cin1} !== {8'hBF, 1'b1}) begin
         errors++; $display("FAIL cmp_issue: got %h %b expected bf 1", b1, cin1);
      end
      run_op(4'hC, 8'h3F, 8'hC0, 8'h00, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (s !== 8'hC2) begin errors++; $display("FAIL bit_status: got %h expected c2", s); end
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL bit_we: got %b expected 0", we); end
      checks++; if (f1 !== 4'h1) begin errors++; $display("FAIL bit_func: got %h expected 1", f1); end
   endtask

   task automatic test_shift;
      int lat; logic [7:0] r, s, b1; logic we, cin1, nn; logic [3:0] f1, f2;
      run_op(4'h8, 8'h01, 8'h00, 8'h01, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (r !== 8'h80) begin errors++; $display("FAIL ror_result: got %h expected 80", r); end
      checks++; if (s !== 8'h81) begin errors++; $display("FAIL ror_status: got %h expected 81", s); end
      checks++; if (nn !== 1'b0) begin errors++; $display("FAIL ror_func_nop: got issue=%b expected 0", nn); end
      run_op(4'h6, 8'h01, 8'h00, 8'h00, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (r !== 8'h00) begin errors++; $display("FAIL lsr_result: got %h expected 00", r); end
      checks++; if (s !== 8'h03) begin errors++; $display("FAIL lsr_status: got %h expected 03", s); end
      checks++; if (nn !== 1'b0) begin errors++; $display("FAIL lsr_func_nop: got issue=%b expected 0", nn); end
   endtask

   task automatic test_table;
      logic [3:0] tc [8] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hA, 4'h0, 4'h0};
      logic [7:0] ta [8] = '{8'hF0, 8'h0F, 8'hFF, 8'h81, 8'h80, 8'h00, 8'h01, 8'hFF};
      logic [7:0] tb [8] = '{8'h3C, 8'hF0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
      logic [7:0] ts [8] = '{8'h00, 8'h00, 8'h81, 8'h00, 8'h01, 8'h00, 8'h24, 8'h00};
      logic [7:0] er [8] = '{8'h30, 8'hFF, 8'h00, 8'h02, 8'h01, 8'hFF, 8'h02, 8'h00};
      logic [7:0] es [8] = '{8'h00, 8'h80, 8'h03, 8'h01, 8'h01, 8'h80, 8'h24, 8'h03};
      int lat; logic [7:0] r, s, b1; logic we, cin1, nn; logic [3:0] f1, f2;
      for (int i = 0; i < 8; i++) begin
         run_op(tc[i], ta[i], tb[i], ts[i], lat, r, s, we, f1, b1, cin1, f2, nn);
         checks++;
         if ({r, s, we} !== {er[i], es[i], 1'b1}) begin
            errors++;
            $display("FAIL table_%0d: got res=%h st=%h we=%b expected res=%h st=%h we=1", i, r, s, we, er[i], es[i]);
         end
      end
   endtask

   task automatic test_bcd;
      int lat; logic [7:0] r, s, b1; logic we, cin1, nn; logic [3:0] f1, f2;
      logic [7:0] exp_adc, exp_sbc; int exp_lat;
`ifdef ALU_SEQ_BCD_EN
      exp_adc = 8'h47; exp_sbc = 8'h29; exp_lat = 5;
`else
      exp_adc = 8'h41; exp_sbc = 8'h2F; exp_lat = 3;
`endif
      run_op(4'h0, 8'h19, 8'h28, 8'h08, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (r !== exp_adc) begin errors++; $display("FAIL bcd_adc_result: got %h expected %h", r, exp_adc); end
      checks++; if (s !== 8'h08) begin errors++; $display("FAIL bcd_adc_status: got %h expected 08", s); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL bcd_adc_latency: got %0d expected %0d", lat, exp_lat); end
      run_op(4'h1, 8'h42, 8'h13, 8'h09, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++; if (r !== exp_sbc) begin errors++; $display("FAIL bcd_sbc_result: got %h expected %h", r, exp_sbc); end
      checks++; if (s !== 8'h09) begin errors++; $display("FAIL bcd_sbc_status: got %h expected 09", s); end
   endtask

   task automatic test_unsupported;
      int lat; logic [7:0] r, s, b1; logic we, cin1, nn; logic [3:0] f1, f2;
      run_op(4'hD, 8'h12, 8'h34, 8'h5A, lat, r, s, we, f1, b1, cin1, f2, nn);
      checks++;
      if ({s, we, nn} !== {8'h5A, 1'b0, 1'b0}) begin
         errors++; $display("FAIL unsup: got st=%h we=%b issue=%b expected st=5a we=0 issue=0", s, we, nn);
      end
      checks++; if (lat != 3) begin errors++; $display("FAIL unsup_latency: got %0d expected 3", lat); end
   endtask

   task automatic test_back_to_back;
      int d1 = -1, d2 = -1; logic [7:0] r1 = 8'h00, r2 = 8'h00, s2 = 8'h00; logic b3 = 1'b1;
      ctrl.cmd = 4'h0; ctrl.op_a = 8'h01; ctrl.op_b = 8'h02; ctrl.status_in = 8'h00; ctrl.req = 1'b1;
      @(posedge phi1); #1;
      ctrl.cmd = 4'h4; ctrl.op_a = 8'hAA; ctrl.op_b = 8'h55;
      for (int e = 0; e < 10; e++) begin
         if (ctrl.done === 1'b1) begin
            if (d1 < 0) begin d1 = e; r1 = ctrl.result; end
            else if (d2 < 0) begin d2 = e; r2 = ctrl.result; s2 = ctrl.status_out; end
         end
         if (e == 3) b3 = ctrl.busy;
         if (e == 4) ctrl.req = 1'b0;
         @(posedge phi1); #1;
      end
      checks++;
      if ({d1, r1} !== {32'sd2, 8'h03}) begin
         errors++; $display("FAIL b2b_first: got edge=%0d res=%h expected edge=2 res=03", d1, r1);
      end
      checks++; if (b3 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", b3); end
      checks++;
      if ({d2, r2, s2} !== {32'sd6, 8'hFF, 8'h80}) begin
         errors++; $display("FAIL b2b_second: got edge=%0d res=%h st=%h expected edge=6 res=ff st=80", d2, r2, s2);
      end
   endtask

   task automatic test_reset_midop;
      logic seen = 1'b0;
      ctrl.cmd = 4'h0; ctrl.op_a = 8'h10; ctrl.op_b = 8'h20; ctrl.status_in = 8'h00; ctrl.req = 1'b1;
      @(posedge phi1); #1;
      ctrl.req = 1'b0;
      @(posedge phi1); #1;
      reset_n = 1'b0;
      @(posedge phi1); #1;
      checks++;
      if ({ctrl.busy, ctrl.done, ctrl.result_we, ctrl.result, ctrl.status_out} !== 19'h0) begin
         errors++;
         $display("FAIL midop_reset_ctrl: got busy=%b done=%b we=%b res=%h st=%h expected all 0",
                  ctrl.busy, ctrl.done, ctrl.result_we, ctrl.result, ctrl.status_out);
      end
      checks++;
      if ({alu_a, alu_b, alu_carry_in, alu_func} !== {8'h00, 8'h00, 1'b0, 4'hF}) begin
         errors++; $display("FAIL midop_reset_alu: got %h %h %b %h expected 00 00 0 f", alu_a, alu_b, alu_carry_in, alu_func);
      end
      reset_n = 1'b1;
      for (int e = 0; e < 5; e++) begin
         if (ctrl.done !== 1'b0) seen = 1'b1;
         @(posedge phi1); #1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_done: got done=%b expected 0", seen); end
   endtask

   initial begin
      ctrl.req = 1'b0; ctrl.cmd = 4'h0; ctrl.op_a = 8'h00; ctrl.op_b = 8'h00; ctrl.status_in = 8'h00;
      test_reset();
      test_adc();
      test_sbc_inc();
      test_cmp_bit();
      test_shift();
      test_table();
      test_bcd();
      test_unsupported();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
